mips_exec_mem_unit: RTL and testbench

Combined control decoder, 32-bit ALU and 128-word data memory for the single-cycle MIPS datapath. It takes the fetched instruction and the two register-file read values. It produces the register-file and PC-mux control signals, the ALU result and zero flag, and the register write-back value. The top level keeps PC, instruction memory and register file; this block covers everything between register read and write-back.

---
 rtl/mips_exec_mem_unit.sv | 131 +++++++++++++
 tb/tb_mips_exec_mem_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_mem_unit.sv
// Single-cycle MIPS execute/memory slice: control decode, 32-bit ALU and a
// word-addressed data memory with synchronous clear on reset.
module mips_exec_mem_unit #(
    parameter int DM_DEPTH = 128,
    parameter int DM_AW    = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Instr,
    input  logic [31:0] Read_data1,
    input  logic [31:0] Read_data2,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        JToPC,
    output logic        Branch,
    output logic [3:0]  ALUOp,
    output logic [31:0] ALU_result,
    output logic        Zero,
    output logic [31:0] DM_Read_data,
    output logic [31:0] Reg_Write_data
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [31:0]  imm;
    logic [31:0]  opB;
    logic         isMemOp;
    alu_op_e      aluOp;
    logic [DM_AW-1:0] dmAddr;
    logic [31:0]  mem_q [DM_DEPTH];
    logic         unused_instr;

    assign opcode       = Instr[31:26];
    assign funct        = Instr[5:0];
    assign imm          = {{16{Instr[15]}}, Instr[15:0]};
    assign isMemOp      = (opcode == 6'h23) || (opcode == 6'h2B);
    assign unused_instr = ^Instr[25:16];

    always_comb begin
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        MemToReg = 1'b0;
        JToPC    = 1'b0;
        Branch   = 1'b0;
        aluOp    = ALU_AND;
        case (opcode)
            6'h00: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                case (funct)
                    6'h20: aluOp = ALU_ADD;
                    6'h22: aluOp = ALU_SUB;
                    6'h24: aluOp = ALU_AND;
                    6'h25: aluOp = ALU_OR;
                    6'h26: aluOp = ALU_XOR;
                    6'h27: aluOp = ALU_NOR;
                    6'h2A: aluOp = ALU_SLT;
                    default: begin
                        RegWrite = 1'b0;
                        aluOp    = ALU_ADD;
                    end
                endcase
            end
            6'h08: begin ALUSrc = 1'b1; RegWrite = 1'b1; aluOp = ALU_ADD; end
            6'h0C: begin ALUSrc = 1'b1; RegWrite = 1'b1; aluOp = ALU_AND; end
            6'h0D: begin ALUSrc = 1'b1; RegWrite = 1'b1; aluOp = ALU_OR;  end
            6'h0A: begin ALUSrc = 1'b1; RegWrite = 1'b1; aluOp = ALU_SLT; end
            6'h23: begin
                ALUSrc   = 1'b1;
                RegWrite = 1'b1;
                MemRead  = 1'b1;
                MemToReg = 1'b1;
                aluOp    = ALU_ADD;
            end
            6'h2B: begin ALUSrc = 1'b1; MemWrite = 1'b1; aluOp = ALU_ADD; end
            6'h04: begin Branch = 1'b1; aluOp = ALU_SUB; end
            6'h02: JToPC = 1'b1;
            default: aluOp = ALU_ADD;
        endcase
    end

    assign ALUOp = aluOp;

    // Loads/stores index words, so the byte offset becomes a word offset.
    assign opB = isMemOp ? {{2{imm[31]}}, imm[31:2]} : (ALUSrc ? imm : Read_data2);

    always_comb begin
        case (ALUOp)
            4'b0000: ALU_result = Read_data1 & opB;
            4'b0001: ALU_result = Read_data1 | opB;
            4'b0010: ALU_result = Read_data1 + opB;
            4'b0011: ALU_result = Read_data1 ^ opB;
            4'b0110: ALU_result = Read_data1 - opB;
            4'b0111: ALU_result = {31'b0, $signed(Read_data1) < $signed(opB)};
            4'b1100: ALU_result = ~(Read_data1 | opB);
            default: ALU_result = 32'b0;
        endcase
    end

    assign Zero   = (ALU_result == 32'b0);
    assign dmAddr = ALU_result[DM_AW-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DM_DEPTH; i++) mem_q[i] <= 32'b0;
        end else if (MemWrite) begin
            mem_q[dmAddr] <= Read_data2;
        end
    end

    assign DM_Read_data   = MemRead ? mem_q[dmAddr] : 32'b0;
    assign Reg_Write_data = MemToReg ? DM_Read_data : ALU_result;

endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// Directed plus randomized checks of mips_exec_mem_unit against an
// instruction-level reference model with its own copy of data memory.
module tb_mips_exec_mem_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Instr, Read_data1, Read_data2;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch;
    logic [3:0]  ALUOp;
    logic [31:0] ALU_result, DM_Read_data, Reg_Write_data;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    logic [31:0] refMem [128];
    logic        eRegDst, eRegWrite, eALUSrc, eMemWrite, eMemRead, eMemToReg, eJToPC, eBranch;
    logic [3:0]  eALUOp;
    logic [31:0] eRes, eDm, eRwd;

    mips_exec_mem_unit dut (
        .CLK(CLK), .RST(RST), .Instr(Instr),
        .Read_data1(Read_data1), .Read_data2(Read_data2),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
        .MemWrite(MemWrite), .MemRead(MemRead), .MemToReg(MemToReg),
        .JToPC(JToPC), .Branch(Branch), .ALUOp(ALUOp),
        .ALU_result(ALU_result), .Zero(Zero),
        .DM_Read_data(DM_Read_data), .Reg_Write_data(Reg_Write_data)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction semantics written directly from the ISA table.
    task automatic refModel(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        logic [5:0]  op;
        logic [31:0] imm, wordOff;
        op  = ins[31:26];
        imm = {{16{ins[15]}}, ins[15:0]};
        wordOff = $signed(imm) >>> 2;
        {eRegDst, eRegWrite, eALUSrc, eMemWrite, eMemRead, eMemToReg, eJToPC, eBranch} = '0;
        eALUOp = 4'b0010;
        eRes   = a + b;
        case (op)
            6'h00: begin
                eRegDst = 1'b1; eRegWrite = 1'b1;
                case (ins[5:0])
                    6'h20: begin eALUOp = 4'b0010; eRes = a + b; end
                    6'h22: begin eALUOp = 4'b0110; eRes = a - b; end
                    6'h24: begin eALUOp = 4'b0000; eRes = a & b; end
                    6'h25: begin eALUOp = 4'b0001; eRes = a | b; end
                    6'h26: begin eALUOp = 4'b0011; eRes = a ^ b; end
                    6'h27: begin eALUOp = 4'b1100; eRes = ~(a | b); end
                    6'h2A: begin eALUOp = 4'b0111; eRes = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                    default: eRegWrite = 1'b0;
                endcase
            end
            6'h08: begin eALUSrc = 1'b1; eRegWrite = 1'b1; eRes = a + imm; end
            6'h0C: begin eALUSrc = 1'b1; eRegWrite = 1'b1; eALUOp = 4'b0000; eRes = a & imm; end
            6'h0D: begin eALUSrc = 1'b1; eRegWrite = 1'b1; eALUOp = 4'b0001; eRes = a | imm; end
            6'h0A: begin
                eALUSrc = 1'b1; eRegWrite = 1'b1; eALUOp = 4'b0111;
                eRes = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            end
            6'h23: begin
                eALUSrc = 1'b1; eRegWrite = 1'b1; eMemRead = 1'b1; eMemToReg = 1'b1;
                eRes = a + wordOff;
            end
            6'h2B: begin eALUSrc = 1'b1; eMemWrite = 1'b1; eRes = a + wordOff; end
            6'h04: begin eBranch = 1'b1; eALUOp = 4'b0110; eRes = a - b; end
            6'h02: begin eJToPC = 1'b1; eALUOp = 4'b0000; eRes = a & b; end
            default: ;
        endcase
        eDm  = eMemRead ? refMem[eRes[6:0]] : 32'd0;
        eRwd = eMemToReg ? eDm : eRes;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, input logic rst);
        Instr = ins; Read_data1 = a; Read_data2 = b; RST = rst;
        refModel(ins, a, b);
        #4;
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".RegDst"},   {31'b0, RegDst},   {31'b0, eRegDst});
        chk({tag, ".RegWrite"}, {31'b0, RegWrite}, {31'b0, eRegWrite});
        chk({tag, ".ALUSrc"},   {31'b0, ALUSrc},   {31'b0, eALUSrc});
        chk({tag, ".MemWrite"}, {31'b0, MemWrite}, {31'b0, eMemWrite});
        chk({tag, ".MemRead"},  {31'b0, MemRead},  {31'b0, eMemRead});
        chk({tag, ".MemToReg"}, {31'b0, MemToReg}, {31'b0, eMemToReg});
        chk({tag, ".JToPC"},    {31'b0, JToPC},    {31'b0, eJToPC});
        chk({tag, ".Branch"},   {31'b0, Branch},   {31'b0, eBranch});
        chk({tag, ".ALUOp"},    {28'b0, ALUOp},    {28'b0, eALUOp});
        chk({tag, ".ALU_result"}, ALU_result, eRes);
        chk({tag, ".Zero"},     {31'b0, Zero},     {31'b0, (eRes == 32'd0)});
        chk({tag, ".DM_Read_data"}, DM_Read_data, eDm);
        chk({tag, ".Reg_Write_data"}, Reg_Write_data, eRwd);
    endtask

    // Advance one edge and apply the same write/clear to the model memory.
    task automatic clockEdge();
        @(posedge CLK);
        if (RST) begin
            for (int i = 0; i < 128; i++) refMem[i] = 32'd0;
        end else if (eMemWrite) begin
            refMem[eRes[6:0]] = Read_data2;
        end
        #1;
    endtask

    initial begin
        logic [5:0] opList [10];
        logic [5:0] fnList [8];
        logic [31:0] ins, a, b;
        logic [5:0] op, fn;
        logic rst;
        opList = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};

        RST = 1'b1; Instr = 32'd0; Read_data1 = 32'd0; Read_data2 = 32'd0;
        for (int i = 0; i < 128; i++) refMem[i] = 32'd0;
        @(posedge CLK); @(posedge CLK); #1;

        applyStimulus(32'h8C000008, 32'd0, 32'd0, 1'b0);
        checkOutput("lw_after_reset");
        chk("lw_after_reset.ALUOp_const", {28'b0, ALUOp}, 32'h2);
        chk("lw_after_reset.result_const", ALU_result, 32'd2);
        chk("lw_after_reset.rwd_const", Reg_Write_data, 32'd0);
        clockEdge();

        applyStimulus(32'hAC000008, 32'd0, 32'hDEADBEEF, 1'b0);
        checkOutput("sw_word2");
        clockEdge();
        applyStimulus(32'h8C000008, 32'd0, 32'd0, 1'b0);
        checkOutput("lw_word2");
        chk("lw_word2.rwd_const", Reg_Write_data, 32'hDEADBEEF);
        clockEdge();

        applyStimulus(32'hAC000008, 32'd0, 32'h12345678, 1'b1);
        clockEdge();
        applyStimulus(32'h8C000008, 32'd0, 32'd0, 1'b0);
        checkOutput("lw_after_rst_write");
        chk("lw_after_rst_write.rwd_const", Reg_Write_data, 32'd0);
        clockEdge();

        applyStimulus(32'h00000020, 32'h7FFFFFFF, 32'd1, 1'b0);
        checkOutput("add_ovf");
        chk("add_ovf.const", ALU_result, 32'h80000000);
        clockEdge();
        applyStimulus(32'h00000022, 32'd5, 32'd5, 1'b0);
        checkOutput("sub_eq");
        chk("sub_eq.zero_const", {31'b0, Zero}, 32'd1);
        clockEdge();
        applyStimulus(32'h0000002A, 32'hFFFFFFFF, 32'd1, 1'b0);
        checkOutput("slt_neg");
        chk("slt_neg.const", ALU_result, 32'd1);
        clockEdge();
        applyStimulus(32'h00000027, 32'd0, 32'd0, 1'b0);
        checkOutput("nor_zero");
        chk("nor_zero.const", ALU_result, 32'hFFFFFFFF);
        clockEdge();

        applyStimulus(32'h10000000, 32'd9, 32'd9, 1'b0);
        checkOutput("beq_eq");
        chk("beq_eq.branch_zero", {30'b0, Branch, Zero}, 32'd3);
        clockEdge();
        applyStimulus(32'h10000000, 32'd9, 32'd8, 1'b0);
        checkOutput("beq_ne");
        clockEdge();

        applyStimulus(32'h08000004, 32'h1234, 32'h5678, 1'b0);
        checkOutput("jump");
        chk("jump.ctl", {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, JToPC, Branch, ALUOp},
            32'b0000_0010_0000);
        clockEdge();
        applyStimulus(32'hFC000000, 32'd1, 32'd2, 1'b0);
        checkOutput("op3F");
        clockEdge();
        applyStimulus(32'h00000000, 32'd1, 32'd2, 1'b0);
        checkOutput("funct00");
        clockEdge();

        applyStimulus(32'hAC000000, 32'd130, 32'hCAFEF00D, 1'b0);
        checkOutput("sw_wrap");
        clockEdge();
        applyStimulus(32'h8C00FFFC, 32'd3, 32'd0, 1'b0);
        checkOutput("lw_wrap");
        chk("lw_wrap.const", Reg_Write_data, 32'hCAFEF00D);
        clockEdge();

        for (int n = 0; n < 400; n++) begin
            op  = opList[$urandom_range(0, 9)];
            fn  = fnList[$urandom_range(0, 7)];
            ins = {op, 26'($urandom)};
            if (op == 6'h00) ins[5:0] = fn;
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if (op == 6'h23 || op == 6'h2B) begin
                a = 32'($urandom_range(0, 300));
                ins[15:0] = 16'($signed($urandom_range(0, 64)) - 32) << 2;
            end
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus(ins, a, b, rst);
            checkOutput("random");
            clockEdge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
